// File: rtl/gate_result_fifo_pkg.sv
// Shared datapath constants for the logic stage, the result FIFO and writeback.
package gate_result_fifo_pkg;

  localparam int unsigned GATE_WIDTH       = 20;
  localparam int unsigned RESULT_FIFO_DEPTH = 4;

endpackage : gate_result_fifo_pkg

// File: rtl/gate_result_fifo.sv
// Show-ahead result FIFO between the bitwise-logic stage and register writeback.
// Occupancy is tracked by an explicit counter so full and empty never rely on pointer compare.
module gate_result_fifo
  import gate_result_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = GATE_WIDTH,
  parameter int unsigned DEPTH = RESULT_FIFO_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PTR_W:0]   count,
  output logic             almost_full
);

  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ALMOST_CNT = (PTR_W+1)'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             do_wr, do_rd;

  assign in_ready    = (count_q != FULL_CNT);
  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= ALMOST_CNT);

  assign do_wr = in_valid  && in_ready;
  assign do_rd = out_valid && out_ready;

  // Flush wins over any transfer in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents are only observed once count marks them valid.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q] <= in_data;
  end

endmodule : gate_result_fifo

// File: doc/gate_result_fifo.md
Name: gate_result_fifo

Overview:
- Buffers 20-bit results produced by the combinational bitwise-logic stage (NOT/AND/OR units) before they reach register writeback.
- Decouples the single-cycle logic stage from a writeback port that may stall.
- Valid/ready handshake on both sides, show-ahead (first-word-fall-through) output, synchronous flush for pipeline squash.

Parameters:
- WIDTH, 20, datapath width in bits; matches the logic-unit operand width.
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries.
- in_data  input  WIDTH  result word from the logic stage.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_data  output  WIDTH  head entry; meaningful only when out_valid=1.
- out_valid  output  1  FIFO is non-empty.
- out_ready  input  1  writeback consumes the head this cycle.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.
- almost_full  output  1  count >= DEPTH-1.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, so out_valid=0, in_ready=1, almost_full=0. Storage contents are don't-care, and out_data is don't-care while out_valid=0. Reset deassertion takes effect at the next clock edge.
- Write: occurs when in_valid && in_ready at a clock edge. mem[wr_ptr] <= in_data, and wr_ptr increments modulo DEPTH (natural PTR_W-bit wrap).
- Read: occurs when out_valid && out_ready at a clock edge. rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH). It is combinational from state only and never depends on out_ready; there is no full-pass-through path.
- out_valid = (count != 0). out_data = mem[rd_ptr], combinational from state (show-ahead).
- Latency: a word written into an empty FIFO at edge N appears on out_data with out_valid=1 after edge N. There is no same-cycle in-to-out bypass.
- Count update:
  - write only: +1
  - read only: -1
  - both: unchanged
  - neither: unchanged
- Full (count=DEPTH): in_ready=0. An in_valid presented while full is held off by the upstream stage; no data is lost or overwritten. A read in that same cycle makes in_ready=1 on the following cycle.
- Empty (count=0): out_valid=0, and out_ready is ignored (no underflow, rd_ptr does not move). A simultaneous write while empty is accepted normally.
- Flush: at a clock edge with flush=1, the pointers and count go to 0. This has priority over any write or read in the same cycle; that write is discarded and that read is not counted. in_ready is not gated by flush.
- Reset mid-operation: all state clears immediately, and in-flight entries are lost.
- Pointer wrap: after DEPTH writes, wr_ptr returns to 0. Ordering is strictly first-in-first-out across the wrap.
- Invariant: count equals (wr_ptr - rd_ptr) mod DEPTH, except when full (count=DEPTH with wr_ptr==rd_ptr). Full and empty are distinguished by count, not by the pointers.

Decomposition:
- Shared package/header: datapath width constant (20) used by the logic gates, this FIFO and writeback; the default FIFO depth constant.
- No typedefs needed.
- No sub-module: storage array, pointers and counter live in one module, since the pointer logic is too small to justify splitting.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> out_valid=0, in_ready=1, count=0, almost_full=0 immediately after the asynchronous assertion.
- Single pass: write 0xFFFFF with out_ready=0 -> next cycle out_valid=1, out_data=0xFFFFF, count=1. Raise out_ready -> after one edge out_valid=0, count=0.
- Fill and stall: write 0x00001, 0x00002, 0x00003, 0x00004 with out_ready=0 -> count=4, in_ready=0, almost_full=1 from count=3. Present 0x00005 while full -> not stored. Drain -> outputs are 1, 2, 3, 4 in order.
- Simultaneous read/write at count=2: write 0x0ABCD while the head is being read -> count stays 2, and FIFO order is preserved across the wr_ptr wrap over 10 pseudo-random words (seed 49448). Each output equals the input at the same index.
- Flush priority: count=3, assert flush together with in_valid=1 (0x12345) and out_ready=1 -> next cycle count=0, out_valid=0, and 0x12345 is absent from later output.
- Asynchronous reset mid-stream: count=2, pulse rst_n low between clock edges -> out_valid drops without waiting for a clock edge. After release, the FIFO accepts 0x54321 and outputs it first.
